regfile_write_scheduler: RTL

//  Sequences the single write port of the register bank. Round-robin arbiter between ALU and load writeback.
//  Per-register pending-write scoreboard; flags read hazards to the issue stage; blocks issue on counter saturation.

---
 rtl/regfile_write_scheduler_pkg.sv | 10 +
 rtl/regfile_write_scheduler_arb.sv | 19 +
 rtl/regfile_write_scheduler.sv | 88 ++++++++
 3 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// regfile_write_scheduler_pkg: shared widths, source ids and register-zero constant
package regfile_write_scheduler_pkg;
  localparam int XLEN = 32;
  localparam int AMOUNT = 16;
  localparam int ADDRESSLEN = 4;
  localparam int CNTW = 2;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LD = 1'b1;
  localparam logic [ADDRESSLEN-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_write_scheduler_arb.sv
// rr_arbiter2: two-way round-robin arbiter; the last-grant flop only moves on a tie
module rr_arbiter2
  import regfile_write_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  always_comb begin
    gnt_o = '0;
    gnt_o[SRC_ALU] = req_i[SRC_ALU] && (!req_i[SRC_LD] || last_q == SRC_LD);
    gnt_o[SRC_LD] = req_i[SRC_LD] && (!req_i[SRC_ALU] || last_q == SRC_ALU);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= SRC_LD;
    else if (&req_i) last_q <= gnt_o[SRC_LD] ? SRC_LD : SRC_ALU;
endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates ALU/load writeback onto the bank write port
// and tracks pending writes per register for issue-stage hazard detection.
module regfile_write_scheduler #(
  parameter int XLEN = regfile_write_scheduler_pkg::XLEN,
  parameter int AMOUNT = regfile_write_scheduler_pkg::AMOUNT,
  parameter int ADDRESSLEN = regfile_write_scheduler_pkg::ADDRESSLEN,
  parameter int CNTW = regfile_write_scheduler_pkg::CNTW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDRESSLEN-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [ADDRESSLEN-1:0] rs1,
  input  logic [ADDRESSLEN-1:0] rs2,
  output logic                  haz1,
  output logic                  haz2,
  input  logic                  a_valid,
  input  logic [ADDRESSLEN-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  l_valid,
  input  logic [ADDRESSLEN-1:0] l_rd,
  input  logic [XLEN-1:0]       l_data,
  output logic                  l_ready,
  output logic                  wr_en,
  output logic [ADDRESSLEN-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data,
  output logic                  sb_err
);
  import regfile_write_scheduler_pkg::SRC_ALU;
  import regfile_write_scheduler_pkg::SRC_LD;
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  logic [1:0] gnt;
  logic [CNTW-1:0] cnt_q [AMOUNT];
  logic [CNTW-1:0] cnt_d [AMOUNT];
  logic wr_en_q, wr_en_d, sb_err_q, sb_err_d;
  logic [ADDRESSLEN-1:0] wr_addr_q, wr_addr_d, w_rd;
  logic [XLEN-1:0] wr_data_q, wr_data_d, w_data;
  logic xfer, iss_oor, w_oor, iss_alloc;
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({l_valid, a_valid}),
    .gnt_o (gnt)
  );
  assign a_ready = gnt[SRC_ALU];
  assign l_ready = gnt[SRC_LD];
  assign xfer = |gnt;
  assign w_rd = gnt[SRC_LD] ? l_rd : a_rd;
  assign w_data = gnt[SRC_LD] ? l_data : a_data;
  assign iss_oor = int'(iss_rd) >= AMOUNT;
  assign w_oor = int'(w_rd) >= AMOUNT;
  // Current count only: a retire in this same cycle gives no credit.
  assign iss_ready = iss_oor || cnt_q[iss_rd] != CNT_MAX;
  assign iss_alloc = iss_valid && iss_ready && !iss_oor && iss_rd != '0;
  assign haz1 = int'(rs1) < AMOUNT && rs1 != '0 && cnt_q[rs1] != '0;
  assign haz2 = int'(rs2) < AMOUNT && rs2 != '0 && cnt_q[rs2] != '0;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign sb_err = sb_err_q;
  always_comb begin
    wr_en_d = xfer && w_rd != '0 && !w_oor;
    wr_addr_d = wr_en_d ? w_rd : wr_addr_q;
    wr_data_d = wr_en_d ? w_data : wr_data_q;
    sb_err_d = sb_err_q || (wr_en_q && cnt_q[wr_addr_q] == '0) || (iss_valid && iss_oor) || (xfer && w_oor);
    for (int r = 0; r < AMOUNT; r++) begin
      cnt_d[r] = (iss_alloc && iss_rd == ADDRESSLEN'(r)) == (wr_en_q && wr_addr_q == ADDRESSLEN'(r)) ? cnt_q[r] :
                 (iss_alloc && iss_rd == ADDRESSLEN'(r)) ? cnt_q[r] + 1'b1 :
                 cnt_q[r] == '0 ? '0 : cnt_q[r] - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sb_err_q <= 1'b0;
      cnt_q <= '{default: '0};
    end else begin
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sb_err_q <= sb_err_d;
      cnt_q <= cnt_d;
    end
endmodule
